// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and defaults for the data-RAM port arbiter: FSM states,
// read-return tags and the scan-length normalisation helper.
package ram_port_arbiter_pkg;

    localparam int ADRS_W_DEF     = 10;
    localparam int MAX_BURST_DEF  = 16;
    localparam int STARVE_MAX_DEF = 8;
    localparam int LEN_W          = 5;

    typedef enum logic {
        ARB_IDLE      = 1'b0,
        ARB_SCN_BURST = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_SCN = 1'b1
    } req_tag_e;

    // A zero length still moves one word; anything past the burst cap is clipped.
    function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len,
                                                 input int max_burst);
        int len_i;
        len_i = int'(len);
        if (len_i == 0) begin
            return LEN_W'(1);
        end
        if (len_i > max_burst) begin
            return LEN_W'(max_burst);
        end
        return len;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundles the CPU, scan-engine and RAM-macro signals around the arbiter.
interface ram_port_arbiter_if
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADRS_W = ADRS_W_DEF
);

    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_adrs;
    logic [31:0]       cpu_wdata;
    logic              cpu_stall;
    logic [31:0]       cpu_rdata;
    logic              cpu_rvalid;

    logic              scn_req;
    logic [31:0]       scn_adrs;
    logic [LEN_W-1:0]  scn_len;
    logic              scn_gnt;
    logic [31:0]       scn_rdata;
    logic              scn_rvalid;
    logic              scn_done;

    logic [ADRS_W-1:0] ram_adrs;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic [31:0]       ram_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_adrs, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  scn_req, scn_adrs, scn_len,
        output scn_gnt, scn_rdata, scn_rvalid, scn_done,
        output ram_adrs, ram_wdata, ram_we,
        input  ram_q
    );

    modport master (
        output cpu_req, cpu_we, cpu_adrs, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output scn_req, scn_adrs, scn_len,
        input  scn_gnt, scn_rdata, scn_rvalid, scn_done,
        input  ram_adrs, ram_wdata, ram_we,
        output ram_q
    );

endinterface

// File: rtl/ram_port_arbiter_burst_counter.sv
// Scan burst sequencer: the first word is issued by the arbiter at load time,
// this block then walks the remaining words with wrap-around addressing.
module arb_burst_counter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADRS_W = ADRS_W_DEF
) (
    input  logic              clk_cpu,
    input  logic              reset,
    input  logic              load,
    input  logic [ADRS_W-1:0] start_adrs,
    input  logic [LEN_W-1:0]  load_len,
    output logic [ADRS_W-1:0] adrs,
    output logic              last,
    output logic              busy
);

    logic [ADRS_W-1:0] adrs_q, adrs_d;
    logic [LEN_W-1:0]  remain_q, remain_d;

    always_comb begin
        adrs_d   = adrs_q;
        remain_d = remain_q;
        if (load) begin
            adrs_d   = start_adrs + ADRS_W'(1);
            remain_d = load_len - LEN_W'(1);
        end else if (remain_q != '0) begin
            adrs_d   = adrs_q + ADRS_W'(1);
            remain_d = remain_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            adrs_q   <= '0;
            remain_q <= '0;
        end else begin
            adrs_q   <= adrs_d;
            remain_q <= remain_d;
        end
    end

    assign adrs = adrs_q;
    assign busy = (remain_q != '0);
    assign last = (remain_q == LEN_W'(1));

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single data-RAM port between CPU loads/stores (priority) and the
// pattern-scan engine's read bursts, with a starvation guard for the scanner.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADRS_W     = ADRS_W_DEF,
    parameter int MAX_BURST  = MAX_BURST_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk_cpu,
    input  logic              reset,
    ram_port_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [ADRS_W-1:0] ram_adrs_q, ram_adrs_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic              rd_vld_q, rd_vld_d;
    req_tag_e          rd_tag_q, rd_tag_d;
    logic              rd_last_q, rd_last_d;

    logic [ADRS_W-1:0] cpu_idx;
    logic [ADRS_W-1:0] scn_idx;
    logic [LEN_W-1:0]  scn_len_n;
    logic              starved;
    logic              in_idle;
    logic              cpu_grant;
    logic              scn_grant;
    logic [ADRS_W-1:0] ctr_adrs;
    logic              ctr_last;
    logic              ctr_busy;
    logic              unused_adrs_bits;

    assign cpu_idx   = bus.cpu_adrs[ADRS_W+1:2];
    assign scn_idx   = bus.scn_adrs[ADRS_W+1:2];
    assign scn_len_n = norm_len(bus.scn_len, MAX_BURST);
    assign unused_adrs_bits = ^{bus.cpu_adrs[31:ADRS_W+2], bus.cpu_adrs[1:0],
                                bus.scn_adrs[31:ADRS_W+2], bus.scn_adrs[1:0]};

    // Grants are gated by reset so every output reads 0 while reset is held.
    assign starved   = bus.scn_req && (starve_cnt_q == CNT_W'(STARVE_MAX));
    assign in_idle   = reset && (state_q == ARB_IDLE);
    assign cpu_grant = in_idle && bus.cpu_req && !starved;
    assign scn_grant = in_idle && bus.scn_req && !cpu_grant;

    arb_burst_counter #(
        .ADRS_W (ADRS_W)
    ) u_burst_counter (
        .clk_cpu    (clk_cpu),
        .reset      (reset),
        .load       (scn_grant),
        .start_adrs (scn_idx),
        .load_len   (scn_len_n),
        .adrs       (ctr_adrs),
        .last       (ctr_last),
        .busy       (ctr_busy)
    );

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        ram_adrs_d   = ram_adrs_q;
        ram_wdata_d  = ram_wdata_q;
        rd_vld_d     = 1'b0;
        rd_tag_d     = REQ_CPU;
        rd_last_d    = 1'b0;

        if (cpu_grant) begin
            ram_adrs_d  = cpu_idx;
            ram_wdata_d = bus.cpu_wdata;
            rd_vld_d    = !bus.cpu_we;
            if (bus.scn_req && (starve_cnt_q < CNT_W'(STARVE_MAX))) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end else if (scn_grant) begin
            ram_adrs_d   = scn_idx;
            rd_vld_d     = 1'b1;
            rd_tag_d     = REQ_SCN;
            rd_last_d    = (scn_len_n == LEN_W'(1));
            starve_cnt_d = '0;
            if (scn_len_n != LEN_W'(1)) begin
                state_d = ARB_SCN_BURST;
            end
        end else if ((state_q == ARB_SCN_BURST) && ctr_busy) begin
            ram_adrs_d = ctr_adrs;
            rd_vld_d   = 1'b1;
            rd_tag_d   = REQ_SCN;
            rd_last_d  = ctr_last;
            if (ctr_last) begin
                state_d = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
            ram_adrs_q   <= '0;
            ram_wdata_q  <= '0;
            rd_vld_q     <= 1'b0;
            rd_tag_q     <= REQ_CPU;
            rd_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            ram_adrs_q   <= ram_adrs_d;
            ram_wdata_q  <= ram_wdata_d;
            rd_vld_q     <= rd_vld_d;
            rd_tag_q     <= rd_tag_d;
            rd_last_q    <= rd_last_d;
        end
    end

    // The return tag steers the registered RAM data to exactly one requester.
    assign bus.ram_adrs   = ram_adrs_d;
    assign bus.ram_wdata  = ram_wdata_d;
    assign bus.ram_we     = cpu_grant && bus.cpu_we;
    assign bus.cpu_stall  = reset && bus.cpu_req && !cpu_grant;
    assign bus.scn_gnt    = scn_grant;
    assign bus.cpu_rvalid = rd_vld_q && (rd_tag_q == REQ_CPU);
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_q : '0;
    assign bus.scn_rvalid = rd_vld_q && (rd_tag_q == REQ_SCN);
    assign bus.scn_rdata  = bus.scn_rvalid ? bus.ram_q : '0;
    assign bus.scn_done   = bus.scn_rvalid && rd_last_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of the arbitration rules.
module tb_ram_port_arbiter;
    import ram_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem [1024];
    bit          mem_init_done = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    ram_port_arbiter_if #(.ADRS_W(10)) bus ();

    ram_port_arbiter #(
        .ADRS_W     (10),
        .MAX_BURST  (16),
        .STARVE_MAX (8)
    ) dut (
        .clk_cpu (clk),
        .reset   (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Registered-read RAM macro: data appears one cycle after the address.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
            end
            mem_init_done <= 1'b1;
        end else begin
            if (bus.ram_we) begin
                mem[bus.ram_adrs] <= bus.ram_wdata;
            end
            bus.ram_q <= mem[bus.ram_adrs];
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_adrs  = '0;
        bus.cpu_wdata = '0;
        bus.scn_req   = 1'b0;
        bus.scn_adrs  = '0;
        bus.scn_len   = '0;
    endtask

    task automatic test_reset();
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b1;
        bus.cpu_adrs = $urandom;
        bus.cpu_wdata = $urandom;
        bus.scn_req  = 1'b1;
        bus.scn_len  = 5'd4;
        #2;
        n_checks++;
        if ({bus.cpu_stall, bus.cpu_rvalid, bus.scn_gnt, bus.scn_rvalid, bus.scn_done, bus.ram_we} !== 6'b0)
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {bus.cpu_stall, bus.cpu_rvalid, bus.scn_gnt, bus.scn_rvalid, bus.scn_done, bus.ram_we});
        else n_pass++;
        n_checks++;
        if ({bus.ram_adrs, bus.ram_wdata, bus.cpu_rdata, bus.scn_rdata} !== '0)
            $display("[TB] FAIL reset_data: got adrs=%h wdata=%h cpu_rdata=%h scn_rdata=%h expected all 0",
                     bus.ram_adrs, bus.ram_wdata, bus.cpu_rdata, bus.scn_rdata);
        else n_pass++;
        idle_inputs();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.cpu_stall, bus.cpu_rvalid, bus.scn_gnt, bus.scn_rvalid, bus.scn_done, bus.ram_we} !== 6'b0)
            $display("[TB] FAIL idle_ctrl: got %b expected 000000",
                     {bus.cpu_stall, bus.cpu_rvalid, bus.scn_gnt, bus.scn_rvalid, bus.scn_done, bus.ram_we});
        else n_pass++;
        n_checks++;
        if (bus.ram_adrs !== 10'h0)
            $display("[TB] FAIL idle_ram_adrs: got %h expected 000", bus.ram_adrs);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_cpu_store_load();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_adrs  = 32'h40;
        bus.cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (bus.ram_adrs !== 10'h010 || bus.ram_we !== 1'b1 || bus.ram_wdata !== 32'hDEAD_BEEF)
            $display("[TB] FAIL store_issue: got adrs=%h we=%b wdata=%h expected 010/1/deadbeef",
                     bus.ram_adrs, bus.ram_we, bus.ram_wdata);
        else n_pass++;
        n_checks++;
        if (bus.cpu_stall !== 1'b0)
            $display("[TB] FAIL store_stall: got %b expected 0", bus.cpu_stall);
        else n_pass++;
        next_cycle();
        bus.cpu_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.ram_adrs !== 10'h010 || bus.ram_we !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.cpu_rvalid !== 1'b0)
            $display("[TB] FAIL load_issue: got adrs=%h we=%b stall=%b rvalid=%b expected 010/0/0/0",
                     bus.ram_adrs, bus.ram_we, bus.cpu_stall, bus.cpu_rvalid);
        else n_pass++;
        next_cycle();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEAD_BEEF)
            $display("[TB] FAIL load_return: got rvalid=%b rdata=%h expected 1/deadbeef",
                     bus.cpu_rvalid, bus.cpu_rdata);
        else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus.cpu_rvalid !== 1'b0)
            $display("[TB] FAIL load_once: got rvalid=%b expected 0", bus.cpu_rvalid);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_scan(input string name, input logic [31:0] adrs, input logic [4:0] len);
        int          n;
        int          pulses;
        logic [9:0]  w;
        logic [9:0]  e;
        n = (len == 5'd0) ? 1 : ((len > 5'd16) ? 16 : int'(len));
        w = adrs[11:2];
        pulses = 0;
        bus.scn_req  = 1'b1;
        bus.scn_adrs = adrs;
        bus.scn_len  = len;
        @(negedge clk);
        n_checks++;
        if (bus.scn_gnt !== 1'b1 || bus.ram_adrs !== w || bus.ram_we !== 1'b0)
            $display("[TB] FAIL %s_gnt: got gnt=%b adrs=%h we=%b expected 1/%h/0",
                     name, bus.scn_gnt, bus.ram_adrs, bus.ram_we, w);
        else n_pass++;
        next_cycle();
        bus.scn_req = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k < n) begin
                e = w + 10'(k);
                n_checks++;
                if (bus.ram_adrs !== e || bus.scn_gnt !== 1'b0 || bus.ram_we !== 1'b0)
                    $display("[TB] FAIL %s_issue%0d: got adrs=%h gnt=%b we=%b expected %h/0/0",
                             name, k, bus.ram_adrs, bus.scn_gnt, bus.ram_we, e);
                else n_pass++;
            end
            if (bus.scn_rvalid === 1'b1) pulses++;
            e = w + 10'(k - 1);
            n_checks++;
            if (bus.scn_rvalid !== 1'b1 || bus.scn_rdata !== mem[e] || bus.scn_done !== (k == n))
                $display("[TB] FAIL %s_ret%0d: got rvalid=%b data=%h done=%b expected 1/%h/%b",
                         name, k, bus.scn_rvalid, bus.scn_rdata, bus.scn_done, mem[e], (k == n));
            else n_pass++;
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (bus.scn_rvalid !== 1'b0 || bus.scn_done !== 1'b0)
            $display("[TB] FAIL %s_tail: got rvalid=%b done=%b expected 0/0",
                     name, bus.scn_rvalid, bus.scn_done);
        else n_pass++;
        n_checks++;
        if (pulses !== n)
            $display("[TB] FAIL %s_pulses: got %0d expected %0d", name, pulses, n);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_cpu_during_burst();
        logic [9:0] w;
        w = 10'h080;
        bus.scn_req  = 1'b1;
        bus.scn_adrs = 32'h200;
        bus.scn_len  = 5'd6;
        @(negedge clk);
        n_checks++;
        if (bus.scn_gnt !== 1'b1)
            $display("[TB] FAIL cdb_gnt: got %b expected 1", bus.scn_gnt);
        else n_pass++;
        next_cycle();
        bus.scn_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus.cpu_req  = (k >= 2);
            bus.cpu_we   = 1'b0;
            bus.cpu_adrs = 32'h40;
            @(negedge clk);
            n_checks++;
            if (bus.ram_adrs !== w + 10'(k) || bus.ram_we !== 1'b0 || bus.cpu_stall !== (k >= 2))
                $display("[TB] FAIL cdb_cycle%0d: got adrs=%h we=%b stall=%b expected %h/0/%b",
                         k, bus.ram_adrs, bus.ram_we, bus.cpu_stall, w + 10'(k), (k >= 2));
            else n_pass++;
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (bus.cpu_stall !== 1'b0 || bus.ram_adrs !== 10'h010)
            $display("[TB] FAIL cdb_cpu_grant: got stall=%b adrs=%h expected 0/010",
                     bus.cpu_stall, bus.ram_adrs);
        else n_pass++;
        n_checks++;
        if (bus.scn_rvalid !== 1'b1 || bus.scn_done !== 1'b1 || bus.scn_rdata !== mem[w + 10'd5])
            $display("[TB] FAIL cdb_last_ret: got rvalid=%b done=%b data=%h expected 1/1/%h",
                     bus.scn_rvalid, bus.scn_done, bus.scn_rdata, mem[w + 10'd5]);
        else n_pass++;
        next_cycle();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== mem[10'h010] || bus.scn_rvalid !== 1'b0)
            $display("[TB] FAIL cdb_cpu_ret: got rvalid=%b data=%h scn_rvalid=%b expected 1/%h/0",
                     bus.cpu_rvalid, bus.cpu_rdata, bus.scn_rvalid, mem[10'h010]);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_starvation();
        int grants;
        bit got;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_adrs = $urandom;
        bus.scn_req  = 1'b1;
        bus.scn_adrs = 32'h300;
        bus.scn_len  = 5'd2;
        for (int round = 0; round < 2; round++) begin
            grants = 0;
            got = 1'b0;
            for (int cyc = 0; cyc < 20 && !got; cyc++) begin
                @(negedge clk);
                if (bus.scn_gnt === 1'b1) begin
                    got = 1'b1;
                    n_checks++;
                    if (bus.cpu_stall !== 1'b1)
                        $display("[TB] FAIL starve%0d_stall_at_gnt: got %b expected 1", round, bus.cpu_stall);
                    else n_pass++;
                end else if (bus.cpu_stall === 1'b0) begin
                    grants++;
                end
                next_cycle();
                bus.cpu_adrs = $urandom;
                if (got) bus.scn_req = 1'b0;
            end
            n_checks++;
            if (!got)
                $display("[TB] FAIL starve%0d_timeout: got no scn_gnt in 20 cycles expected one", round);
            else n_pass++;
            n_checks++;
            if (grants !== 8)
                $display("[TB] FAIL starve%0d_grants: got %0d expected 8", round, grants);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (bus.cpu_stall !== 1'b1)
                $display("[TB] FAIL starve%0d_burst_stall: got %b expected 1", round, bus.cpu_stall);
            else n_pass++;
            next_cycle();
            bus.scn_req = 1'b1;
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        bus.scn_req  = 1'b1;
        bus.scn_adrs = $urandom;
        bus.scn_len  = 5'd8;
        @(negedge clk);
        next_cycle();
        bus.scn_req = 1'b0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        next_cycle();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.scn_rvalid, bus.scn_done, bus.ram_we, bus.cpu_stall, bus.scn_gnt} !== 5'b0 || bus.ram_adrs !== 10'h0)
            $display("[TB] FAIL rmb_reset_outputs: got ctrl=%b adrs=%h expected 00000/000",
                     {bus.scn_rvalid, bus.scn_done, bus.ram_we, bus.cpu_stall, bus.scn_gnt}, bus.ram_adrs);
        else n_pass++;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.scn_rvalid !== 1'b0 || bus.scn_done !== 1'b0)
                $display("[TB] FAIL rmb_quiet%0d: got rvalid=%b done=%b expected 0/0",
                         i, bus.scn_rvalid, bus.scn_done);
            else n_pass++;
            next_cycle();
        end
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_adrs = 32'h84;
        @(negedge clk);
        n_checks++;
        if (bus.cpu_stall !== 1'b0 || bus.ram_adrs !== 10'h021)
            $display("[TB] FAIL rmb_idle_grant: got stall=%b adrs=%h expected 0/021",
                     bus.cpu_stall, bus.ram_adrs);
        else n_pass++;
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_random(input int n_cyc);
        logic [31:0] shadow [1024];
        int          busy_rem, burst_k, starve, n;
        logic [9:0]  burst_base, cidx, sidx, a;
        bit          pend, c_req, c_we, g_cpu, g_scn, busy;
        logic [31:0] p_adrs, c_adrs, c_wdata;
        logic [4:0]  p_len;
        bit          ecr, esr, esd;
        logic [31:0] ecd, esdat;
        for (int i = 0; i < 1024; i++) shadow[i] = mem[i];
        busy_rem = 0; burst_k = 0; starve = 0; pend = 1'b0;
        ecr = 1'b0; esr = 1'b0; esd = 1'b0; ecd = '0; esdat = '0;
        burst_base = '0; p_adrs = '0; p_len = '0;
        for (int cyc = 0; cyc < n_cyc; cyc++) begin
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend   = 1'b1;
                p_adrs = $urandom;
                p_len  = 5'($urandom_range(0, 31));
            end
            c_req   = ($urandom_range(0, 9) < 6);
            c_we    = 1'($urandom_range(0, 1));
            c_adrs  = $urandom;
            c_wdata = $urandom;
            bus.scn_req   = pend;
            bus.scn_adrs  = p_adrs;
            bus.scn_len   = p_len;
            bus.cpu_req   = c_req;
            bus.cpu_we    = c_we;
            bus.cpu_adrs  = c_adrs;
            bus.cpu_wdata = c_wdata;
            cidx  = c_adrs[11:2];
            sidx  = p_adrs[11:2];
            busy  = (busy_rem > 0);
            g_cpu = !busy && c_req && !(pend && starve == 8);
            g_scn = !busy && pend && !g_cpu;
            a     = burst_base + 10'(burst_k);
            @(negedge clk);
            n_checks++;
            if (bus.cpu_stall !== (c_req && !g_cpu) || bus.scn_gnt !== g_scn || bus.ram_we !== (g_cpu && c_we))
                $display("[TB] FAIL rnd%0d_ctrl: got stall=%b gnt=%b we=%b expected %b/%b/%b", cyc,
                         bus.cpu_stall, bus.scn_gnt, bus.ram_we, (c_req && !g_cpu), g_scn, (g_cpu && c_we));
            else n_pass++;
            if (g_cpu || g_scn || busy) begin
                n_checks++;
                if (bus.ram_adrs !== (g_cpu ? cidx : (g_scn ? sidx : a)))
                    $display("[TB] FAIL rnd%0d_adrs: got %h expected %h", cyc,
                             bus.ram_adrs, (g_cpu ? cidx : (g_scn ? sidx : a)));
                else n_pass++;
            end
            if (g_cpu && c_we) begin
                n_checks++;
                if (bus.ram_wdata !== c_wdata)
                    $display("[TB] FAIL rnd%0d_wdata: got %h expected %h", cyc, bus.ram_wdata, c_wdata);
                else n_pass++;
            end
            n_checks++;
            if (bus.cpu_rvalid !== ecr || (ecr && bus.cpu_rdata !== ecd))
                $display("[TB] FAIL rnd%0d_cpu_ret: got rvalid=%b data=%h expected %b/%h", cyc,
                         bus.cpu_rvalid, bus.cpu_rdata, ecr, ecd);
            else n_pass++;
            n_checks++;
            if (bus.scn_rvalid !== esr || bus.scn_done !== esd || (esr && bus.scn_rdata !== esdat))
                $display("[TB] FAIL rnd%0d_scn_ret: got rvalid=%b done=%b data=%h expected %b/%b/%h", cyc,
                         bus.scn_rvalid, bus.scn_done, bus.scn_rdata, esr, esd, esdat);
            else n_pass++;

            ecr = g_cpu && !c_we;
            ecd = shadow[cidx];
            if (g_cpu && c_we) shadow[cidx] = c_wdata;
            if (g_cpu && pend && starve < 8) starve++;
            if (g_scn) begin
                n = (p_len == 5'd0) ? 1 : ((p_len > 5'd16) ? 16 : int'(p_len));
                burst_base = sidx;
                burst_k    = 1;
                busy_rem   = n - 1;
                esr   = 1'b1;
                esdat = shadow[sidx];
                esd   = (n == 1);
                starve = 0;
                pend   = 1'b0;
            end else if (busy) begin
                esr   = 1'b1;
                esdat = shadow[a];
                busy_rem--;
                burst_k++;
                esd   = (busy_rem == 0);
            end else begin
                esr = 1'b0;
                esd = 1'b0;
            end
            next_cycle();
        end
        idle_inputs();
        for (int i = 0; i < 20; i++) next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_cpu_store_load();
        test_scan("scan_len4", 32'h100, 5'd4);
        test_scan("scan_wrap", 32'hFF8, 5'd4);
        test_scan("scan_len0", 32'h2A4, 5'd0);
        test_scan("scan_len31", 32'h7C0, 5'd31);
        test_cpu_during_burst();
        test_starvation();
        test_reset_mid_burst();
        test_random(400);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
